// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync-FIFO write port between NREQ valid/ready producers.
// Optional stall statistics counter enabled by defining FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
   parameter int NREQ      = 4,
   parameter int DWIDTH    = 16,
   parameter int MAX_BURST = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*DWIDTH-1:0]   req_data,
   output logic [NREQ-1:0]          req_ready,
   input  logic                     fifo_full,
   output logic                     fifo_wr_en,
   output logic [DWIDTH-1:0]        fifo_din,
   output logic [NREQ-1:0]          grant,
   output logic                     busy,
   output logic [15:0]              stall_cnt
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [IW-1:0]   sel;
   logic            sel_found;
   logic            own_valid;
   logic [DWIDTH-1:0] own_data;

   // Current owner's valid and data slice.
   always_comb begin
      own_valid = 1'b0;
      own_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (owner_q == IW'(i)) begin
            own_valid = req_valid[i];
            own_data  = req_data[i*DWIDTH +: DWIDTH];
         end
      end
   end

   // First valid requester scanning from rr_ptr with wrap-around.
   always_comb begin : rr_select
      int idx;
      idx       = 0;
      sel       = rr_ptr_q;
      sel_found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!sel_found && req_valid[idx]) begin
            sel       = IW'(idx);
            sel_found = 1'b1;
         end
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_d    = state_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      count_d    = count_q;
      grant_d    = grant_q;
      req_ready  = '0;
      fifo_wr_en = 1'b0;
      fifo_din   = own_data;
      busy       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sel_found) begin
               state_d = BURST;
               owner_d = sel;
               grant_d = NREQ'(1) << sel;
               count_d = '0;
            end
         end
         BURST: begin
            busy       = 1'b1;
            req_ready  = fifo_full ? '0 : grant_q;
            fifo_wr_en = own_valid & !fifo_full;
            if (!own_valid || (fifo_wr_en && count_q == LAST_BEAT)) begin
               state_d  = IDLE;
               grant_d  = '0;
               count_d  = '0;
               rr_ptr_d = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
            end else if (fifo_wr_en) begin
               count_d = count_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         count_q  <= '0;
         grant_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         count_q  <= count_d;
         grant_q  <= grant_d;
      end
   end

   assign grant = grant_q;

`ifdef FIFO_WR_ARB_STATS_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of cycles the owner wanted to write but the FIFO was full.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (busy && own_valid && fifo_full && stall_cnt_q != 16'hFFFF)
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter with producer models and a write scoreboard.
module tb_fifo_wr_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 16;
   localparam int MB   = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*DW-1:0]   req_data;
   logic [NREQ-1:0]      req_ready;
   logic                 fifo_full;
   logic                 fifo_wr_en;
   logic [DW-1:0]        fifo_din;
   logic [NREQ-1:0]      grant;
   logic                 busy;
   logic [15:0]          stall_cnt;

   fifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
      .fifo_din(fifo_din), .grant(grant), .busy(busy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NREQ-1:0] g;
      logic [DW-1:0]   d;
   } exp_t;

   exp_t            exp_q[$];
   logic [DW-1:0]   src [NREQ][$];
   logic [NREQ-1:0] en;
   logic [NREQ-1:0] acc;
   logic [NREQ-1:0] prev_grant;
   int              burst_len;
   int              checks;
   int              errors;
   exp_t            e;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]         = en[i] && (src[i].size() > 0);
         req_data[i*DW +: DW] = (src[i].size() > 0) ? src[i][0] : '0;
      end
   endtask

   task automatic push_exp(input int owner, input logic [DW-1:0] d);
      exp_t x;
      x.g = NREQ'(1) << owner;
      x.d = d;
      exp_q.push_back(x);
   endtask

   // Mid-cycle sampling: invariants plus scoreboard on each FIFO write.
   task automatic sample();
      @(negedge clk);
      check("no_write_when_full", 32'(fifo_wr_en && fifo_full), 0);
      check("grant_onehot0", 32'($onehot0(grant)), 1);
      check("ready_within_grant", 32'(req_ready & ~grant), 0);
      check("busy_matches_grant", 32'(busy), 32'(grant != '0));
      check("no_back_to_back", 32'(grant != '0 && prev_grant != '0 && grant != prev_grant), 0);
      if (grant == '0) burst_len = 0;
      if (fifo_wr_en) begin
         burst_len++;
         check("burst_len_bound", 32'(burst_len <= MB), 1);
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(fifo_din), 32'hDEAD_0000);
         end else begin
            e = exp_q.pop_front();
            check("sb_grant", 32'(grant), 32'(e.g));
            check("sb_din", 32'(fifo_din), 32'(e.d));
         end
      end
      prev_grant = grant;
      acc = req_valid & req_ready;
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) if (acc[i]) void'(src[i].pop_front());
      drive();
   endtask

   task automatic step();
      sample();
      advance();
   endtask

   task automatic run_until(input int left, input int budget, input string tag);
      int k = 0;
      while (exp_q.size() > left && k < budget) begin
         step();
         k++;
      end
      check(tag, 32'(exp_q.size() <= left), 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0; burst_len = 0; prev_grant = '0;
      rst = 1'b1; fifo_full = 1'b0; en = '0; req_valid = '0; req_data = '0; acc = '0;

      // Reset state
      step(); step();
      sample();
      check("rst_grant", 32'(grant), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_wr_en", 32'(fifo_wr_en), 0);
      check("rst_ready", 32'(req_ready), 0);
      check("rst_stall", 32'(stall_cnt), 0);
      rst = 1'b0;
      advance();

      // Single requester: 4-beat burst, idle, 2 more beats, release on drop
      for (int j = 0; j < 6; j++) begin
         src[0].push_back(16'hA000 + 16'(j));
         push_exp(0, 16'hA000 + 16'(j));
      end
      en[0] = 1'b1;
      drive();
      sample();
      check("t1_no_grant_yet", 32'(grant), 0);
      advance();
      sample();
      check("t1_grant_after_1", 32'(grant), 32'b0001);
      advance();
      run_until(0, 40, "t1_drain");
      sample();
      check("t1_drop_grant_held", 32'(grant), 32'b0001);
      check("t1_drop_no_write", 32'(fifo_wr_en), 0);
      advance();
      sample();
      check("t1_released", 32'(grant), 0);
      advance();

      // rr_ptr=1 after release: req1 wins over req0
      src[0].push_back(16'hB000);
      src[1].push_back(16'hB100);
      en[1] = 1'b1;
      push_exp(1, 16'hB100);
      push_exp(0, 16'hB000);
      drive();
      run_until(0, 20, "rr_ptr_order");
      repeat (3) step();
      en = '0;
      drive();

      // Rotation from reset: 0,1,2,3,0,1,2,3 bursts of 4
      do_reset();
      for (int i = 0; i < NREQ; i++)
         for (int j = 0; j < 8; j++)
            src[i].push_back(16'hC000 | 16'(i << 8) | 16'(j));
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < MB; j++)
               push_exp(i, 16'hC000 | 16'(i << 8) | 16'(r*MB + j));
      en = '1;
      drive();
      run_until(0, 100, "rotation_drain");
      repeat (3) step();
      en = '0;
      drive();

      // Full stall on req1 after 2 beats, 5 cycles
      for (int j = 0; j < 4; j++) begin
         src[1].push_back(16'hD100 + 16'(j));
         push_exp(1, 16'hD100 + 16'(j));
      end
      en[1] = 1'b1;
      drive();
      run_until(2, 20, "stall_first_two");
      fifo_full = 1'b1;
      for (int c = 0; c < 5; c++) begin
         sample();
         check("stall_grant_held", 32'(grant), 32'b0010);
         check("stall_no_write", 32'(fifo_wr_en), 0);
         check("stall_no_ready", 32'(req_ready), 0);
         advance();
      end
      fifo_full = 1'b0;
      run_until(0, 20, "stall_drain");
      repeat (2) step();
`ifdef FIFO_WR_ARB_STATS_EN
      check("stall_cnt_5", 32'(stall_cnt), 5);
`else
      check("stall_cnt_tied0", 32'(stall_cnt), 0);
`endif
      en = '0;
      drive();

      // Reset during req0's second beat (rr_ptr is 2 here)
      for (int j = 0; j < 6; j++) src[0].push_back(16'hF000 + 16'(j));
      push_exp(0, 16'hF000);
      push_exp(0, 16'hF001);
      en[0] = 1'b1;
      drive();
      run_until(1, 20, "rst_first_beat");
      rst = 1'b1;
      advance_after_sample: begin
         sample();
         advance();
      end
      rst = 1'b0;
      src[3].push_back(16'hF300);
      en[3] = 1'b1;
      for (int j = 2; j < 6; j++) push_exp(0, 16'hF000 + 16'(j));
      push_exp(3, 16'hF300);
      drive();
      sample();
      check("midrst_grant", 32'(grant), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_wr_en", 32'(fifo_wr_en), 0);
      check("midrst_ready", 32'(req_ready), 0);
      check("midrst_stall", 32'(stall_cnt), 0);
      advance();
      run_until(0, 30, "midrst_restart");
      repeat (3) step();
      en = '0;
      drive();

      // Early drop: req2 drops after one beat while req3 waits
      src[2].push_back(16'hE200);
      src[2].push_back(16'hE201);
      src[3].push_back(16'hE300);
      push_exp(2, 16'hE200);
      push_exp(3, 16'hE300);
      en[2] = 1'b1;
      en[3] = 1'b1;
      drive();
      run_until(1, 20, "drop_first_beat");
      en[2] = 1'b0;
      drive();
      sample();
      check("drop_no_write", 32'(fifo_wr_en), 0);
      check("drop_grant_held", 32'(grant), 32'b0100);
      advance();
      sample();
      check("drop_idle", 32'(grant), 0);
      advance();
      run_until(0, 20, "drop_regrant");
      src[2].delete();
      repeat (3) step();
      en = '0;
      drive();

`ifdef FIFO_WR_ARB_STATS_EN
      // Saturation: owner held off by full for 70000 cycles
      src[2].push_back(16'h5A5A);
      push_exp(2, 16'h5A5A);
      en[2] = 1'b1;
      fifo_full = 1'b1;
      drive();
      repeat (70000) step();
      check("sat_reached", 32'(stall_cnt), 32'hFFFF);
      repeat (5) step();
      check("sat_held", 32'(stall_cnt), 32'hFFFF);
      fifo_full = 1'b0;
      run_until(0, 10, "sat_drain");
      repeat (3) step();
      en = '0;
      drive();
`endif

      check("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares the single write port of a sync FIFO between NREQ producers.
- Each producer presents a valid/ready/data stream.
- The arbiter grants one producer at a time for a bounded burst, then rotates.
- It drives the FIFO's wr_en/din and obeys its full flag.
- Sits directly in front of the FIFO write side; the read side is untouched.

Parameters:
NREQ, 4, number of requesters (2..8)
DWIDTH, 16, data width, matches FIFO DWIDTH
MAX_BURST, 4, max beats accepted per grant before forced rotation (>=1)

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous active-high reset
req_valid  input  NREQ  per-requester data valid
req_data  input  NREQ*DWIDTH  packed data, requester i at bits [i*DWIDTH +: DWIDTH]
req_ready  output  NREQ  per-requester accept; beat transfers when valid&ready
fifo_full  input  1  FIFO full flag
fifo_wr_en  output  1  FIFO write enable
fifo_din  output  DWIDTH  FIFO write data
grant  output  NREQ  one-hot current owner, registered; 0 when idle
busy  output  1  high while in BURST
stall_cnt  output  16  stall statistics (see Optional Feature)

Behaviour:
- FSM states IDLE, BURST.
- Registers: state, owner index, rr_ptr, beat count of width clog2(MAX_BURST+1).
- Reset (and reset mid-burst): state=IDLE, grant=0, owner=0, rr_ptr=0, count=0, stall_cnt=0.
  - req_ready=0 and fifo_wr_en=0 from the first cycle after the reset edge.
  - An interrupted burst is not resumed.
- IDLE: req_ready=0, fifo_wr_en=0, busy=0.
  - If any req_valid is set, select the first set bit scanning rr_ptr, rr_ptr+1, ... with wrap mod NREQ.
  - Next edge: state=BURST, owner=selected, grant=one-hot(selected), count=0.
  - Latency: valid asserted at edge N -> grant visible after edge N+1 -> first beat can transfer in that cycle.
- BURST (combinational outputs):
  - req_ready[owner]=!fifo_full; all other req_ready=0.
  - fifo_wr_en=req_valid[owner] & !fifo_full.
  - fifo_din=req_data slice of owner, regardless of wr_en.
- Accepted beat = fifo_wr_en high at an edge; count increments.
- Release at an edge when either condition holds:
  - (a) an accepted beat brings count to MAX_BURST;
  - (b) req_valid[owner]=0.
- On release: state=IDLE, grant=0, count=0, rr_ptr=(owner+1) mod NREQ.
- Exactly one idle cycle always follows a release; no back-to-back grants.
- fifo_full high in BURST: no transfer, count held, grant held indefinitely (no timeout). Condition (b) still releases.
- Non-owner valids are ignored in BURST; no preemption.
- rr_ptr changes only on release.
- MAX_BURST=1: every accepted beat releases.
- Each requester must hold data stable while valid&!ready; the arbiter does not check this.
- Never writes while fifo_full=1. Never asserts more than one req_ready or grant bit.

Optional Feature:
Macro FIFO_WR_ARB_STATS_EN.
- Defined: stall_cnt is a 16-bit saturating counter (stops at 0xFFFF).
  - Increments at each edge where state=BURST, req_valid[owner]=1 and fifo_full=1.
  - Cleared only by rst.
- Undefined: stall_cnt tied to 0; counter logic absent.
- Arbitration behaviour is identical in both builds.

Test Plan:
- Single requester: NREQ=4, req_valid=0001, fifo_full=0, 6 beats 0xA000..0xA005.
  -> grant=0001 one cycle after valid; 4 consecutive wr_en with 0xA000..0xA003; one idle cycle; re-grant to req0; 0xA004, 0xA005.
  -> Release on valid drop; rr_ptr=1.
- Rotation: all four valid continuously, MAX_BURST=4.
  -> Grant order 0,1,2,3,0, each burst exactly 4 writes separated by 1 idle cycle.
  -> fifo_din always equals the owner's data slice.
- Full stall: req1 granted; fifo_full=1 after 2 beats, held 5 cycles, then 0.
  -> No wr_en during stall; grant stays 0010; remaining 2 beats written after full drops.
  -> With STATS_EN, stall_cnt=5.
- Early drop: req2 owner drops valid after 1 beat while req3 is valid.
  -> Release at that edge; idle cycle; grant=1000.
  -> No wr_en while req_valid[2]=0.
- Reset mid-burst: rst high for 1 cycle during req0's 2nd beat.
  -> Next cycle grant=0, busy=0, wr_en=0, stall_cnt=0; arbitration restarts from req0.
- Saturation (STATS_EN): hold fifo_full=1 with owner valid for 70000 cycles.
  -> stall_cnt=0xFFFF and stays there.
